// File: rtl/store_port_arbiter_pkg.sv
// Shared constants and helpers for the D$ store-port arbiter.
package store_port_arbiter_pkg;

    localparam int unsigned STORE_ARB_MAX_PORTS = 32'd4;

    // Next round-robin start position after granting port id.
    function automatic int unsigned rr_next(input int unsigned id, input int unsigned nr_ports);
        return (id + 32'd1 >= nr_ports) ? 32'd0 : id + 32'd1;
    endfunction

endpackage

// File: rtl/store_port_id_fifo.sv
// In-order FIFO of requester IDs for granted writes still waiting on their ack.
module store_port_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_s, pop_s;

    // Pointer and occupancy next-state; push guarded by full, pop by empty.
    always_comb begin
        push_s = push_i && !full_o;
        pop_s  = pop_i && !empty_o;
        wr_d   = push_s ? wr_q + PTR_W'(1) : wr_q;
        rd_d   = pop_s  ? rd_q + PTR_W'(1) : rd_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= {PTR_W{1'b0}};
            rd_q  <= {PTR_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_s) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == {CNT_W{1'b0}});
    assign count_o = cnt_q;

endmodule

// File: rtl/store_port_arbiter.sv
// Round-robin arbiter for the single D$ store port; holds a selection until
// granted and routes in-order write acks back to the issuing requester.
module store_port_arbiter
    import store_port_arbiter_pkg::*;
#(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned ADDR_W   = 56,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MAX_OUT  = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NR_PORTS-1:0]                  req_i,
    input  logic [NR_PORTS-1:0][ADDR_W-1:0]      addr_i,
    input  logic [NR_PORTS-1:0][DATA_W-1:0]      wdata_i,
    input  logic [NR_PORTS-1:0][DATA_W/8-1:0]    be_i,
    input  logic [NR_PORTS-1:0][1:0]             size_i,
    output logic [NR_PORTS-1:0]                  gnt_o,
    output logic [NR_PORTS-1:0]                  ack_o,
    output logic                                 req_o,
    output logic [ADDR_W-1:0]                    addr_o,
    output logic [DATA_W-1:0]                    wdata_o,
    output logic [DATA_W/8-1:0]                  be_o,
    output logic [1:0]                           size_o,
    input  logic                                 gnt_i,
    input  logic                                 ack_i,
    output logic                                 idle_o,
    output logic                                 err_o
);
    localparam int unsigned ID_W  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] sel_q, sel_d, rr_q, rr_d, pick_s, sel_s, head_s;
    logic            pick_vld_s, hit_s, req_s, push_s, pop_s;
    logic            full_s, empty_s, err_q, err_d;
    logic [CNT_W-1:0] count_s;
    int unsigned     idx_s;

    // Cyclic search for the first requester at or after rr_q.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_s     = {ID_W{1'b0}};
        hit_s      = 1'b0;
        idx_s      = 32'd0;
        for (int unsigned k = 0; k < NR_PORTS; k++) begin
            idx_s      = 32'(rr_q) + k;
            idx_s      = (idx_s >= NR_PORTS) ? idx_s - NR_PORTS : idx_s;
            hit_s      = !pick_vld_s && req_i[idx_s];
            pick_s     = hit_s ? ID_W'(idx_s) : pick_s;
            pick_vld_s = pick_vld_s | hit_s;
        end
    end

    // State, selection, round-robin pointer and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= {ID_W{1'b0}};
            rr_q    <= {ID_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    // Next-state: an ungranted pick is latched; a hold ends on grant or dropped request.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (req_s && !gnt_i) begin
                    state_d = HOLD;
                    sel_d   = pick_s;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (gnt_i || !req_i[sel_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
        rr_d  = push_s ? ID_W'(rr_next(32'(sel_s), NR_PORTS)) : rr_q;
        err_d = err_q | (ack_i & empty_s);
    end

    // Outputs: full-blocking looks only at the registered count, so a same-cycle pop never unblocks.
    always_comb begin
        if (state_q == HOLD) begin
            sel_s = sel_q;
            req_s = req_i[sel_q];
        end else begin
            sel_s = pick_s;
            req_s = pick_vld_s && !full_s;
        end
        push_s = req_s && gnt_i;
        pop_s  = ack_i && !empty_s;
        gnt_o  = {NR_PORTS{1'b0}};
        gnt_o[sel_s] = push_s;
        ack_o  = {NR_PORTS{1'b0}};
        ack_o[head_s] = pop_s;
        req_o  = req_s;
        if (req_s) begin
            addr_o  = addr_i[sel_s];
            wdata_o = wdata_i[sel_s];
            be_o    = be_i[sel_s];
            size_o  = size_i[sel_s];
        end else begin
            addr_o  = {ADDR_W{1'b0}};
            wdata_o = {DATA_W{1'b0}};
            be_o    = {(DATA_W/8){1'b0}};
            size_o  = 2'b00;
        end
        idle_o = (state_q == IDLE) && (count_s == {CNT_W{1'b0}}) && !req_s;
        err_o  = err_q;
    end

    store_port_id_fifo #(
        .DEPTH (MAX_OUT),
        .W     (ID_W)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .data_i  (sel_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

endmodule

// File: tb/tb_store_port_arbiter.sv
// Self-checking bench for store_port_arbiter against a queue-based reference model.
module tb_store_port_arbiter;
    localparam int NP = 2;
    localparam int AW = 56;
    localparam int DW = 64;
    localparam int MO = 4;

    logic                       clk;
    logic                       rst_ni;
    logic [NP-1:0]              req_i;
    logic [NP-1:0][AW-1:0]      addr_i;
    logic [NP-1:0][DW-1:0]      wdata_i;
    logic [NP-1:0][DW/8-1:0]    be_i;
    logic [NP-1:0][1:0]         size_i;
    logic [NP-1:0]              gnt_o, ack_o;
    logic                       req_o, gnt_i, ack_i, idle_o, err_o;
    logic [AW-1:0]              addr_o;
    logic [DW-1:0]              wdata_o;
    logic [DW/8-1:0]            be_o;
    logic [1:0]                 size_o;

    store_port_arbiter #(.NR_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .be_i(be_i), .size_i(size_i), .gnt_o(gnt_o), .ack_o(ack_o), .req_o(req_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o),
        .gnt_i(gnt_i), .ack_i(ack_i), .idle_o(idle_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: outstanding grant IDs in order, rr start, held selection
    int      m_q[$];
    int      m_rr, m_held;
    bit      m_hold, m_err;
    // expectations for the current cycle
    logic          exp_req, exp_idle, exp_err;
    int            exp_sel;
    logic [NP-1:0] exp_gnt, exp_ack;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW/8-1:0] exp_be;
    logic [1:0]    exp_size;
    logic [NP-1:0] cur_r;
    logic          cur_g, cur_a;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic apply(input logic [NP-1:0] r, input logic g, input logic a);
        int p;
        req_i = r; gnt_i = g; ack_i = a;
        cur_r = r; cur_g = g; cur_a = a;
        for (int i = 0; i < NP; i++) begin
            addr_i[i]  = {$urandom, $urandom};
            wdata_i[i] = {$urandom, $urandom};
            be_i[i]    = 8'($urandom);
            size_i[i]  = 2'($urandom);
        end
        exp_req = 1'b0;
        exp_sel = 0;
        if (m_hold) begin
            exp_sel = m_held;
            exp_req = r[m_held];
        end else if (m_q.size() < MO) begin
            for (int k = 0; k < NP; k++) begin
                p = (m_rr + k) % NP;
                if (!exp_req && r[p]) begin
                    exp_req = 1'b1;
                    exp_sel = p;
                end
            end
        end
        exp_gnt = '0;
        if (exp_req && g) exp_gnt[exp_sel] = 1'b1;
        exp_ack = '0;
        if (a && m_q.size() > 0) exp_ack[m_q[0]] = 1'b1;
        exp_idle  = !m_hold && (m_q.size() == 0) && !exp_req;
        exp_err   = m_err;
        exp_addr  = exp_req ? addr_i[exp_sel]  : '0;
        exp_wdata = exp_req ? wdata_i[exp_sel] : '0;
        exp_be    = exp_req ? be_i[exp_sel]    : '0;
        exp_size  = exp_req ? size_i[exp_sel]  : 2'b00;
        #2;
    endtask

    task automatic tick();
        if (!rst_ni) begin
            m_q.delete();
            m_rr = 0; m_hold = 1'b0; m_held = 0; m_err = 1'b0;
        end else begin
            if (cur_a && m_q.size() > 0) void'(m_q.pop_front());
            else if (cur_a) m_err = 1'b1;
            if (exp_req && cur_g) begin
                m_q.push_back(exp_sel);
                m_rr = (exp_sel + 1) % NP;
            end
            if (m_hold) begin
                if (cur_g || !cur_r[m_held]) m_hold = 1'b0;
            end else if (exp_req && !cur_g) begin
                m_hold = 1'b1;
                m_held = exp_sel;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < MO + 2; i++) begin
            apply('0, 1'b0, m_q.size() > 0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        apply('0, 1'b0, 1'b0); tick();
        apply('0, 1'b0, 1'b0); tick();
        rst_ni = 1'b1;
        apply('0, 1'b0, 1'b0);
        n_tests++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", req_o); end
        n_tests++; if (gnt_o !== '0) begin n_fail++; $display("FAIL rst_gnt got %b exp 0", gnt_o); end
        n_tests++; if (ack_o !== '0) begin n_fail++; $display("FAIL rst_ack got %b exp 0", ack_o); end
        n_tests++; if (addr_o !== '0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", addr_o); end
        n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b exp 1", idle_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err_o); end
        tick();
    endtask

    task automatic test_single();
        apply(2'b01, 1'b1, 1'b0);
        addr_i[0] = 56'h1000;
        #1;
        n_tests++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL single_gnt got %b exp 01", gnt_o); end
        n_tests++; if (addr_o !== 56'h1000) begin n_fail++; $display("FAIL single_addr got %h exp 1000", addr_o); end
        tick();
        apply('0, 1'b0, 1'b0);
        n_tests++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b exp 0", idle_o); end
        tick();
        apply('0, 1'b0, 1'b0); tick();
        apply('0, 1'b0, 1'b1);
        n_tests++; if (ack_o !== 2'b01) begin n_fail++; $display("FAIL single_ack got %b exp 01", ack_o); end
        tick();
        apply('0, 1'b0, 1'b0);
        n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL single_idle got %b exp 1", idle_o); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] prev;
        prev = '0;
        for (int i = 0; i < 6; i++) begin
            apply(2'b11, 1'b1, m_q.size() > 0);
            n_tests++; if (gnt_o !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b exp %b", i, gnt_o, exp_gnt); end
            if (i > 0) begin
                n_tests++; if (gnt_o === prev) begin n_fail++; $display("FAIL rr_alt[%0d] got %b exp not %b", i, gnt_o, prev); end
            end
            prev = gnt_o;
            tick();
        end
        drain();
    endtask

    task automatic test_hold();
        apply(2'b10, 1'b0, 1'b0);
        n_tests++; if (addr_o !== addr_i[1]) begin n_fail++; $display("FAIL hold_sel got %h exp %h", addr_o, addr_i[1]); end
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(2'b11, 1'b0, 1'b0);
            n_tests++; if (addr_o !== addr_i[1] || req_o !== 1'b1 || gnt_o !== 2'b00) begin
                n_fail++; $display("FAIL hold_keep[%0d] got %h/%b/%b exp %h/1/00", i, addr_o, req_o, gnt_o, addr_i[1]);
            end
            tick();
        end
        apply(2'b11, 1'b1, 1'b0);
        n_tests++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL hold_gnt1 got %b exp 10", gnt_o); end
        tick();
        apply(2'b01, 1'b1, 1'b0);
        n_tests++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL hold_gnt0 got %b exp 01", gnt_o); end
        tick();
        drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < MO; i++) begin
            apply(2'b01, 1'b1, 1'b0);
            n_tests++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL full_fill[%0d] got %b exp 01", i, gnt_o); end
            tick();
        end
        apply(2'b01, 1'b1, 1'b0);
        n_tests++; if (req_o !== 1'b0 || gnt_o !== 2'b00) begin n_fail++; $display("FAIL full_block got %b/%b exp 0/00", req_o, gnt_o); end
        tick();
        apply(2'b01, 1'b1, 1'b1);
        n_tests++; if (req_o !== 1'b0 || ack_o !== 2'b01) begin n_fail++; $display("FAIL full_pop got %b/%b exp 0/01", req_o, ack_o); end
        tick();
        apply(2'b01, 1'b1, 1'b0);
        n_tests++; if (req_o !== 1'b1 || gnt_o !== 2'b01) begin n_fail++; $display("FAIL full_reissue got %b/%b exp 1/01", req_o, gnt_o); end
        tick();
        drain();
    endtask

    task automatic test_push_pop();
        apply(2'b10, 1'b1, 1'b0); tick();
        apply(2'b01, 1'b1, 1'b0); tick();
        apply(2'b11, 1'b1, 1'b1);
        n_tests++; if (ack_o !== 2'b10) begin n_fail++; $display("FAIL pp_ack got %b exp 10", ack_o); end
        n_tests++; if (gnt_o !== exp_gnt) begin n_fail++; $display("FAIL pp_gnt got %b exp %b", gnt_o, exp_gnt); end
        tick();
        for (int i = 0; i < 2; i++) begin
            apply('0, 1'b0, 1'b1);
            n_tests++; if (ack_o !== exp_ack) begin n_fail++; $display("FAIL pp_drain[%0d] got %b exp %b", i, ack_o, exp_ack); end
            tick();
        end
        apply('0, 1'b0, 1'b0);
        n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL pp_count got idle %b exp 1", idle_o); end
        tick();
    endtask

    task automatic test_random();
        logic [NP-1:0] r;
        for (int c = 0; c < 400; c++) begin
            r = NP'($urandom);
            if (m_hold && ($urandom_range(15) != 0)) r[m_held] = 1'b1;
            apply(r, 1'($urandom), (m_q.size() > 0) && 1'($urandom));
            n_tests++;
            if (req_o !== exp_req || gnt_o !== exp_gnt || ack_o !== exp_ack || idle_o !== exp_idle ||
                err_o !== exp_err || addr_o !== exp_addr || wdata_o !== exp_wdata ||
                be_o !== exp_be || size_o !== exp_size) begin
                n_fail++;
                $display("FAIL rand[%0d] got req%b gnt%b ack%b idle%b err%b addr%h exp req%b gnt%b ack%b idle%b err%b addr%h",
                         c, req_o, gnt_o, ack_o, idle_o, err_o, addr_o,
                         exp_req, exp_gnt, exp_ack, exp_idle, exp_err, exp_addr);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_in_hold();
        for (int i = 0; i < 3; i++) begin
            apply(2'b01, 1'b1, 1'b0); tick();
        end
        apply(2'b10, 1'b0, 1'b0); tick();
        rst_ni = 1'b0;
        apply(2'b10, 1'b0, 1'b0); tick();
        rst_ni = 1'b1;
        apply('0, 1'b0, 1'b0);
        n_tests++; if (req_o !== 1'b0 || gnt_o !== '0 || ack_o !== '0 || addr_o !== '0 || idle_o !== 1'b1 || err_o !== 1'b0) begin
            n_fail++; $display("FAIL rsthold_outs got req%b gnt%b ack%b idle%b err%b exp 0/00/00/1/0", req_o, gnt_o, ack_o, idle_o, err_o);
        end
        tick();
        apply('0, 1'b0, 1'b1);
        n_tests++; if (ack_o !== 2'b00) begin n_fail++; $display("FAIL rsthold_lateack got %b exp 00", ack_o); end
        tick();
        apply('0, 1'b0, 1'b0);
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL rsthold_err got %b exp 1", err_o); end
        tick();
        apply('0, 1'b0, 1'b0);
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL rsthold_sticky got %b exp 1", err_o); end
        tick();
    endtask

    initial begin
        rst_ni = 1'b0; req_i = '0; gnt_i = 1'b0; ack_i = 1'b0;
        addr_i = '0; wdata_i = '0; be_i = '0; size_i = '0;
        m_rr = 0; m_held = 0; m_hold = 1'b0; m_err = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_full();
        test_push_pop();
        test_random();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule

// File: doc/store_port_arbiter.md
# store_port_arbiter

Round-robin arbiter sharing the single D$ store/write request port between `NR_PORTS` requesters (store buffer, AMO buffer, future requesters). It sits between the store unit's buffers and the data cache. It holds a selection stable until the cache grants it, and tracks granted-but-unacknowledged writes in an ID FIFO so each write acknowledge is routed back to its originating port. It exposes an idle flag for fence/flush sequencing.

## Interface
- `NR_PORTS`, 2 — number of requesters (2..4)
- `ADDR_W`, 56 — physical address width (riscv::PLEN)
- `DATA_W`, 64 — write data width (riscv::XLEN)
- `MAX_OUT`, 4 — max outstanding granted writes awaiting ack (power of 2, ≥2)
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; one clock; reset is synchronous and active-low
- `req_i`  in  NR_PORTS  per-port write request
- `addr_i`  in  NR_PORTS×ADDR_W  per-port physical address
- `wdata_i`  in  NR_PORTS×DATA_W  per-port aligned write data
- `be_i`  in  NR_PORTS×DATA_W/8  per-port byte enables
- `size_i`  in  NR_PORTS×2  per-port transfer size
- `gnt_o`  out  NR_PORTS  one-hot grant, same cycle as `gnt_i`
- `ack_o`  out  NR_PORTS  one-hot write-complete pulse
- `req_o`  out  1  request to D$
- `addr_o`, `wdata_o`, `be_o`, `size_o`  out  ADDR_W/DATA_W/DATA_W/8/2  selected port's fields
- `gnt_i`  in  1  D$ accepts request this cycle
- `ack_i`  in  1  D$ write complete, in grant order
- `idle_o`  out  1  no request held and FIFO empty
- `err_o`  out  1  sticky: `ack_i` received with empty FIFO

## Operation
- States: IDLE (no selection) and HOLD (selection `sel_q` latched, `req_o`=1).
- IDLE: if FIFO not full and any `req_i`, pick first requesting port at or after `rr_q` (cyclic), drive `req_o`/fields combinationally from that port this cycle. If `gnt_i` the same cycle, complete, else latch `sel_q`, go HOLD.
- HOLD: `req_o`=1, fields muxed from `sel_q`; no re-arbitration. On `gnt_i` go IDLE. Requesters must hold `req_i` and fields stable until `gnt_o`; if `req_i[sel_q]` drops, go IDLE without grant (protocol violation, tolerated).
- On grant: `gnt_o[sel]`=1, push `sel` into ID FIFO, `rr_q` ← sel+1 mod NR_PORTS.
- FIFO full (MAX_OUT entries): no new selection from IDLE; a HOLD in progress keeps `req_o` only if it entered while not full (cannot occur, since entry requires a free slot, so push never overflows).
- `ack_i`: pop head, pulse `ack_o[head]` same cycle. Pop and push in the same cycle are both allowed; count unchanged. Full-blocking uses the registered count (pop does not unblock same cycle).
- `ack_i` with empty FIFO: ignored, `err_o` set until reset.
- `idle_o` = state IDLE && count==0 && !req_o.

## Timing
- Arbitration to `req_o`: 0 cycles (combinational from `req_i`, registered state).
- `gnt_i`→`gnt_o`: combinational; `ack_i`→`ack_o`: combinational.
- Reset (sync, `rst_ni`=0 at clock edge): state IDLE, `rr_q`=0, FIFO empty, count 0, `err_o`=0. Outputs after reset: `req_o`=0, `gnt_o`=0, `ack_o`=0, fields 0, `idle_o`=1. Reset mid-HOLD or with outstanding entries discards them; late `ack_i` after reset sets `err_o`.
- `idle_o` registered-state based; goes 1 the cycle after last ack pop.

## Structure
- FIFO of `$clog2(NR_PORTS)`-bit port IDs as sub-module `store_port_id_fifo` (depth MAX_OUT, push/pop/full/empty/count, sync active-low reset).
- No new package typedefs; state enum local. If promoted, `STORE_ARB_PORTS` constant goes in ariane_pkg.

## Test plan
- Single req: port0 req, addr 0x1000, `gnt_i` same cycle → `gnt_o`=01, FIFO count 1; `ack_i` 2 cycles later → `ack_o`=01, `idle_o`=1 next cycle.
- Round robin: ports 0,1 requesting continuously, `gnt_i`=1 always → grants alternate 0,1,0,1; `rr_q` toggles.
- Hold: port1 selected, `gnt_i` low 3 cycles while port0 raises req → `req_o` fields stay port1's; port1 granted on cycle 4, then port0.
- Full: MAX_OUT=4 grants with no acks → 5th request not issued (`req_o`=0); one `ack_i` → request issued next cycle.
- Simultaneous push/pop at count 2 → count stays 2, correct `ack_o` for head ID, `gnt_o` for new.
- Reset in HOLD with 3 outstanding → all outputs reset values; subsequent `ack_i` → `err_o`=1 sticky.
